be_word_assembler: RTL and testbench

- Byte-stream to word deserializer. It is the read/assemble direction of the team's big-endian word storage.
- Accepts WIDTH-bit bytes on a valid/ready input. Packs WORD of them most-significant-first into one FULLW-bit word.
- Presents the word on a registered valid/ready output.
- Sits between byte-wide sources (UART/loader/memory byte port) and word-wide consumers (instruction/data memory fill, CPSR/register load).

---
 rtl/be_word_assembler_pkg.sv | 15 +
 rtl/be_out_slot.sv | 65 ++++++
 rtl/be_word_assembler.sv | 83 ++++++++
 tb/tb_be_word_assembler.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/be_word_assembler_pkg.sv
// Shared sizing defaults and byte-lane helper for the big-endian word storage path.
// Byte k of a word occupies the k-th lane counted from the MSB end.
package be_word_assembler_pkg;

    localparam int BE_WIDTH = 8;
    localparam int BE_WORD  = 4;
    localparam int BE_FULLW = BE_WIDTH * BE_WORD;
    localparam int BE_CNTW  = 3;

    // LSB position of byte index k inside a word of `word` bytes, byte 0 in the MSB lane
    function automatic int be_lane_lsb(input int k, input int word, input int width);
        return (word - 1 - k) * width;
    endfunction

endpackage

// File: rtl/be_out_slot.sv
// Single-entry registered output holding slot with valid/ready handshake.
// A load always wins over a pop, so back-to-back words stream without a bubble.
module be_out_slot
    import be_word_assembler_pkg::*;
#(
    parameter int FULLW = BE_FULLW,
    parameter int CNTW  = BE_CNTW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [FULLW-1:0] word,
    input  logic [CNTW-1:0]  count,
    input  logic             last,
    output logic             ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [FULLW-1:0] out_data,
    output logic [CNTW-1:0]  out_count,
    output logic             out_last
);

    logic             valid_q, valid_d;
    logic [FULLW-1:0] data_q, data_d;
    logic [CNTW-1:0]  count_q, count_d;
    logic             last_q, last_d;

    assign ready = !valid_q || out_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        count_d = count_q;
        last_d  = last_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = word;
            count_d = count;
            last_d  = last;
        end else if (valid_q && out_ready) begin
            // Payload is deliberately left in place after a pop
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            count_q <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            count_q <= count_d;
            last_q  <= last_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_count = count_q;
    assign out_last  = last_q;

endmodule

// File: rtl/be_word_assembler.sv
// Byte-stream to big-endian word deserializer: packs WORD bytes MSB-first,
// flushing a partial word early when in_last is seen.
module be_word_assembler
    import be_word_assembler_pkg::*;
#(
    parameter int WIDTH = BE_WIDTH,
    parameter int WORD  = BE_WORD,
    parameter int FULLW = WIDTH * WORD,
    parameter int CNTW  = BE_CNTW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [FULLW-1:0] out_data,
    output logic [CNTW-1:0]  out_count,
    output logic             out_last
);

    logic [CNTW-1:0]  idx_q, idx_d;
    logic [FULLW-1:0] asm_q, asm_d;
    logic [FULLW-1:0] merged;
    logic             accept;
    logic             complete;

    assign accept   = in_valid && in_ready;
    assign complete = accept && ((idx_q == CNTW'(WORD - 1)) || in_last);

    always_comb begin
        merged = asm_q;
        for (int k = 0; k < WORD; k++) begin
            if (idx_q == CNTW'(k)) begin
                merged[be_lane_lsb(k, WORD, WIDTH) +: WIDTH] = in_data;
            end
        end
    end

    always_comb begin
        idx_d = idx_q;
        asm_d = asm_q;
        if (complete) begin
            // The finished word moves to the output slot; start the next one clean
            idx_d = '0;
            asm_d = '0;
        end else if (accept) begin
            idx_d = idx_q + CNTW'(1);
            asm_d = merged;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            asm_q <= '0;
        end else begin
            idx_q <= idx_d;
            asm_q <= asm_d;
        end
    end

    be_out_slot #(
        .FULLW (FULLW),
        .CNTW  (CNTW)
    ) u_out_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (complete),
        .word      (merged),
        .count     (idx_q + CNTW'(1)),
        .last      (in_last),
        .ready     (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_last  (out_last)
    );

endmodule

// File: tb/tb_be_word_assembler.sv
// Self-checking bench for be_word_assembler: directed scenarios plus a random
// stream scored against a message-level reference model.
module tb_be_word_assembler;

    localparam int WIDTH = 8;
    localparam int WORD  = 4;
    localparam int FULLW = 32;
    localparam int CNTW  = 3;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [FULLW-1:0] out_data;
    logic [CNTW-1:0]  out_count;
    logic             out_last;

    be_word_assembler #(
        .WIDTH (WIDTH),
        .WORD  (WORD),
        .FULLW (FULLW),
        .CNTW  (CNTW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [FULLW-1:0] data;
        int               count;
        bit               last;
    } word_t;

    word_t      exp_q[$];
    logic [7:0] part_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    bit         accepted;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: collect bytes of the current message, emit a word at WORD bytes or on last
    task automatic model_byte(input logic [7:0] b, input bit l);
        word_t w;
        part_q.push_back(b);
        if (part_q.size() == WORD || l) begin
            w.data = '0;
            for (int i = 0; i < part_q.size(); i++)
                w.data = w.data | (FULLW'(part_q[i]) << (8 * (WORD - 1 - i)));
            w.count = part_q.size();
            w.last  = l;
            exp_q.push_back(w);
            part_q.delete();
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        part_q.delete();
    endtask

    // One clock: observe handshakes at the falling edge, then return 1ns after the rising edge
    task automatic tick();
        bit exp_ready;
        @(negedge clk);
        accepted = 1'b0;
        if (!rst_n) begin
            model_clear();
        end else begin
            exp_ready = (exp_q.size() == 0) || out_ready;
            check("out_valid", out_valid, exp_q.size() != 0);
            check("in_ready", in_ready, exp_ready);
            if (out_valid && exp_q.size() != 0) begin
                check("out_data", out_data, exp_q[0].data);
                check("out_count", out_count, exp_q[0].count);
                check("out_last", out_last, exp_q[0].last);
                if (out_ready) void'(exp_q.pop_front());
            end
            if (in_valid && exp_ready) begin
                accepted = 1'b1;
                model_byte(in_data, in_last);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input bit l, output int cycles);
        in_valid = 1'b1;
        in_data  = b;
        in_last  = l;
        cycles   = 0;
        do begin
            tick();
            cycles++;
        end while (!accepted && cycles < 100);
        if (!accepted) check("send_timeout", 1, 0);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit last_on_4th);
        int c;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] tmp;
            tmp = w >> (8 * (3 - i));
            send(tmp[7:0], last_on_4th && (i == 3), c);
        end
    endtask

    task automatic expect_out(input string tag, input logic [31:0] d, input int c, input bit l);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_data"}, out_data, d);
        check({tag, "_count"}, out_count, c);
        check({tag, "_last"}, out_last, l);
    endtask

    initial begin
        int c;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_count", out_count, 0);
        check("rst_last", out_last, 0);
        rst_n = 1'b1;

        // Full word, output visible for exactly one cycle
        out_ready = 1'b1;
        send_word(32'h12345678, 1'b0);
        expect_out("full", 32'h12345678, 4, 1'b0);
        tick();
        check("full_one_cycle", out_valid, 0);

        // Partial word flushed by last, then next byte starts at index 0
        send(8'hAA, 1'b0, c);
        send(8'hBB, 1'b1, c);
        expect_out("partial", 32'hAABB0000, 2, 1'b1);
        send_word(32'h01020304, 1'b0);
        expect_out("after_partial", 32'h01020304, 4, 1'b0);

        send(8'hCD, 1'b1, c);
        expect_out("single", 32'hCD000000, 1, 1'b1);
        send_word(32'h89ABCDEF, 1'b1);
        expect_out("full_last", 32'h89ABCDEF, 4, 1'b1);
        tick();

        // Eight-byte stream at full rate: every byte accepted on its first cycle
        for (int i = 0; i < 8; i++) begin
            send(8'(i), 1'b0, c);
            check("stream_no_stall", c, 1);
            if (i == 3) expect_out("stream_w0", 32'h00010203, 4, 1'b0);
        end
        expect_out("stream_w1", 32'h04050607, 4, 1'b0);
        tick();

        // Stall: word held while sink is not ready
        out_ready = 1'b0;
        send_word(32'hDEADBEEF, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("stall_in_ready", in_ready, 0);
            check("stall_data", out_data, 32'hDEADBEEF);
            tick();
        end
        out_ready = 1'b1;
        send_word(32'hCAFEF00D, 1'b0);
        expect_out("after_stall", 32'hCAFEF00D, 4, 1'b0);
        tick();

        // Asynchronous reset in the middle of a word with a stale word on the outputs
        send(8'h11, 1'b0, c);
        send(8'h22, 1'b0, c);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_data", out_data, 0);
        check("arst_count", out_count, 0);
        check("arst_last", out_last, 0);
        model_clear();
        @(posedge clk);
        #1 rst_n = 1'b1;
        send_word(32'h33445566, 1'b0);
        expect_out("post_rst", 32'h33445566, 4, 1'b0);
        tick();

        // Random stream with random back-pressure and message boundaries
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_data   = 8'($urandom);
            in_last   = ($urandom_range(0, 5) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
